// File: rtl/dmem_handshake_ctrl.sv
// dmem_handshake_ctrl: bridges the memory stage's single-cycle load/store
// request onto a variable-latency req/ack data memory, stalling the pipeline
// until the access completes or is aborted.
// Optional feature macro: DMEM_ALIGN_CHECK_EN rejects odd byte addresses.
module dmem_handshake_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          req;
  logic          bad_req;

  assign req = MemRead | MemWrite;

  // Requests rejected without touching memory.
  always_comb begin
    bad_req = MemRead & MemWrite;
`ifdef DMEM_ALIGN_CHECK_EN
    bad_req = bad_req | addr[0];
`endif
  end

  // Hold the pipeline while a request is being accepted or is in flight.
  assign stall = ((state == IDLE) && req) || (state == WAIT);

  // Access sequencer with registered memory-side and completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          cnt  <= '0;
          if (req) begin
            if (bad_req) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_wr    <= MemWrite;
              mem_addr  <= addr;
              mem_wdata <= wdata;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            // Ack wins over a coincident timeout.
            mem_req <= 1'b0;
            if (!mem_wr) rdata <= mem_rdata;
            done  <= 1'b1;
            err   <= 1'b0;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_handshake_ctrl.sv
// Directed testbench for dmem_handshake_ctrl with TIMEOUT=8.
module tb_dmem_handshake_ctrl;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        stall;
  logic [15:0] rdata;
  logic        done;
  logic        err;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int total;
  int bad;

  dmem_handshake_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .done(done), .err(err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] wd;
    logic        ack;
    logic [15:0] mrd;
    logic        e_stall;
    logic        e_done;
    logic        e_err;
    logic        e_mreq;
    logic        e_mwr;
    logic [15:0] e_maddr;
    logic [15:0] e_mwdata;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic wr, logic [15:0] a, logic [15:0] wd,
                              logic ack, logic [15:0] mrd,
                              logic st, logic dn, logic er, logic mrq, logic mw,
                              logic [15:0] ma, logic [15:0] mwd, logic [15:0] rdt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.ack = ack; v.mrd = mrd;
    v.e_stall = st; v.e_done = dn; v.e_err = er; v.e_mreq = mrq; v.e_mwr = mw;
    v.e_maddr = ma; v.e_mwdata = mwd; v.e_rdata = rdt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic ack, input logic [15:0] mrd);
    MemRead = rd; MemWrite = wr; addr = a; wdata = wd; mem_ack = ack; mem_rdata = mrd;
  endtask

  task automatic chk_all(input string tag, input logic st, input logic dn, input logic er,
                         input logic mrq, input logic mw, input logic [15:0] ma,
                         input logic [15:0] mwd, input logic [15:0] rdt);
    chk({tag, " stall"}, 16'(stall), 16'(st));
    chk({tag, " done"}, 16'(done), 16'(dn));
    chk({tag, " err"}, 16'(err), 16'(er));
    chk({tag, " mem_req"}, 16'(mem_req), 16'(mrq));
    chk({tag, " mem_wr"}, 16'(mem_wr), 16'(mw));
    chk({tag, " mem_addr"}, mem_addr, ma);
    chk({tag, " mem_wdata"}, mem_wdata, mwd);
    chk({tag, " rdata"}, rdata, rdt);
  endtask

  logic [15:0] exp_rd;
  logic [15:0] exp_ma;
  logic        exp_mw;
  logic [15:0] exp_mwd;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b1;

    // Read 0x0010, ack in cycle 3 with 0xBEEF.
    vecs.push_back(mk(1,0,16'h0010,16'h0,0,16'h0,    1,0,0,0,0,16'h0000,16'h0,16'h0000));
    vecs.push_back(mk(1,0,16'h0010,16'h0,0,16'h0,    1,0,0,1,0,16'h0010,16'h0,16'h0000));
    vecs.push_back(mk(1,0,16'h0010,16'h0,0,16'h0,    1,0,0,1,0,16'h0010,16'h0,16'h0000));
    vecs.push_back(mk(1,0,16'h0010,16'h0,1,16'hBEEF, 1,0,0,1,0,16'h0010,16'h0,16'h0000));
    vecs.push_back(mk(1,0,16'h0010,16'h0,0,16'h0,    0,1,0,0,0,16'h0010,16'h0,16'hBEEF));
    vecs.push_back(mk(0,0,16'h0000,16'h0,0,16'h0,    0,0,0,0,0,16'h0010,16'h0,16'hBEEF));
    // Write 0x1234 to 0x0020, ack in cycle 1 with junk read data.
    vecs.push_back(mk(0,1,16'h0020,16'h1234,0,16'h0,    1,0,0,0,0,16'h0010,16'h0000,16'hBEEF));
    vecs.push_back(mk(0,1,16'h0020,16'h1234,1,16'hDEAD, 1,0,0,1,1,16'h0020,16'h1234,16'hBEEF));
    vecs.push_back(mk(0,1,16'h0020,16'h1234,0,16'h0,    0,1,0,0,1,16'h0020,16'h1234,16'hBEEF));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0,    0,0,0,0,1,16'h0020,16'h1234,16'hBEEF));
    // Illegal read+write; then a stray ack in IDLE.
    vecs.push_back(mk(1,1,16'h0030,16'h9999,0,16'h0,    1,0,0,0,1,16'h0020,16'h1234,16'hBEEF));
    vecs.push_back(mk(1,1,16'h0030,16'h9999,0,16'h0,    0,1,1,0,1,16'h0020,16'h1234,16'hBEEF));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1,16'h5555, 0,0,0,0,1,16'h0020,16'h1234,16'hBEEF));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0,16'h0,    0,0,0,0,1,16'h0020,16'h1234,16'hBEEF));
`ifdef DMEM_ALIGN_CHECK_EN
    // Odd address rejected without a memory access.
    vecs.push_back(mk(1,0,16'h0011,16'h0,0,16'h0,    1,0,0,0,1,16'h0020,16'h1234,16'hBEEF));
    vecs.push_back(mk(1,0,16'h0011,16'h0,1,16'h0A0A, 0,1,1,0,1,16'h0020,16'h1234,16'hBEEF));
    vecs.push_back(mk(0,0,16'h0000,16'h0,0,16'h0,    0,0,0,0,1,16'h0020,16'h1234,16'hBEEF));
    exp_rd = 16'hBEEF; exp_ma = 16'h0020; exp_mw = 1'b1; exp_mwd = 16'h1234;
`else
    // Odd address passes through as a normal read.
    vecs.push_back(mk(1,0,16'h0011,16'h0,0,16'h0,    1,0,0,0,1,16'h0020,16'h1234,16'hBEEF));
    vecs.push_back(mk(1,0,16'h0011,16'h0,1,16'h0A0A, 1,0,0,1,0,16'h0011,16'h0000,16'hBEEF));
    vecs.push_back(mk(1,0,16'h0011,16'h0,0,16'h0,    0,1,0,0,0,16'h0011,16'h0000,16'h0A0A));
    vecs.push_back(mk(0,0,16'h0000,16'h0,0,16'h0,    0,0,0,0,0,16'h0011,16'h0000,16'h0A0A));
    exp_rd = 16'h0A0A; exp_ma = 16'h0011; exp_mw = 1'b0; exp_mwd = 16'h0000;
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].ack, vecs[i].mrd);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_done, vecs[i].e_err,
              vecs[i].e_mreq, vecs[i].e_mwr, vecs[i].e_maddr, vecs[i].e_mwdata, vecs[i].e_rdata);
    end

    // Read with no ack: timeout after 8 WAIT cycles.
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      drive(c <= 9, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0);
      #1;
      chk($sformatf("to%0d stall", c), 16'(stall), 16'(c <= 8));
      chk($sformatf("to%0d mem_req", c), 16'(mem_req), 16'(c >= 1 && c <= 8));
      chk($sformatf("to%0d done", c), 16'(done), 16'(c == 9));
      chk($sformatf("to%0d err", c), 16'(err), 16'(c == 9));
      chk($sformatf("to%0d rdata", c), rdata, exp_rd);
    end

    // Ack coincident with the last count: completes without error.
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      drive(c <= 9, 1'b0, 16'h0042, 16'h0, c == 8, (c == 8) ? 16'h7777 : 16'h0);
      #1;
      chk($sformatf("al%0d stall", c), 16'(stall), 16'(c <= 8));
      chk($sformatf("al%0d mem_req", c), 16'(mem_req), 16'(c >= 1 && c <= 8));
      chk($sformatf("al%0d done", c), 16'(done), 16'(c == 9));
      chk($sformatf("al%0d err", c), 16'(err), 16'h0);
      chk($sformatf("al%0d rdata", c), rdata, (c >= 9) ? 16'h7777 : exp_rd);
    end

    // Reset asserted in WAIT cycle 2, late ack after release.
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rstw mem_req before", 16'(mem_req), 16'h1);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    rst = 1'b0;
    #1;
    chk_all("rstw async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      #1;
      chk($sformatf("late%0d done", c), 16'(done), 16'h0);
      chk($sformatf("late%0d mem_req", c), 16'(mem_req), 16'h0);
      chk($sformatf("late%0d rdata", c), rdata, 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Unused-result guard for configuration-specific expectations.
  initial begin
    #1;
    exp_ma  = exp_ma;
    exp_mw  = exp_mw;
    exp_mwd = exp_mwd;
  end

endmodule
